// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bist_pkg
// Purpose  : Shared types and helpers for the BIST vector engine.
//            - state_t    : engine FSM states
//            - DEF_POLY   : default MISR feedback polynomial
//            - misr_step  : one MISR compaction step (width-generic, <= 32)
//            - lfsr_taps  : Fibonacci LFSR tap masks per vector width
// Revision : 1.0 - initial release
// ============================================================================
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] DEF_POLY = 8'h1D;

   // sig_next = (sig << 1) ^ (msb ? poly : 0) ^ din, all truncated to w bits.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] din,
                                             input logic [31:0] poly,
                                             input int          w);
      logic [31:0] mask;
      logic [31:0] nxt;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      nxt  = (sig << 1) & mask;
      if (((sig >> (w - 1)) & 32'd1) != 32'd0) begin
         nxt = nxt ^ poly;
      end
      nxt = nxt ^ din;
      return nxt & mask;
   endfunction

   // Tap masks for a left-shifting Fibonacci LFSR; the feedback bit is the
   // XOR of the masked state bits. Each mask gives a maximal-length sequence.
   function automatic logic [7:0] lfsr_taps(input int n);
      case (n)
         2:       return 8'h03;
         3:       return 8'h06;
         4:       return 8'h0C;
         5:       return 8'h14;
         6:       return 8'h30;
         7:       return 8'h60;
         8:       return 8'hB8;
         default: return 8'h06;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/bist_misr.sv
`default_nettype none
// ============================================================================
// Module   : bist_misr
// Purpose  : SIG_W-bit signature register. Loads din_i when en_i is high;
//            the parent computes the next signature (compaction or clear).
// Ports    : clk, rst (async, active-high)
//            en_i  - load enable
//            din_i - next signature value
//            q_o   - current signature
// Revision : 1.0 - initial release
// ============================================================================
module bist_misr
   import bist_pkg::*;
#(
   parameter int SIG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [SIG_W-1:0] din_i,
   output logic [SIG_W-1:0] q_o
);

   logic [SIG_W-1:0] sig_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else if (en_i) begin
         sig_q <= din_i;
      end
   end

   assign q_o = sig_q;

endmodule
`default_nettype wire

// File: rtl/bist_vector_engine.sv
`default_nettype none
// ============================================================================
// Module   : bist_vector_engine
// Purpose  : Drives a vector sequence into a combinational DUT, holds each
//            vector HOLD_CYC cycles, compacts the DUT response into a MISR
//            at the end of each hold and flags pass/fail against GOLDEN.
// Ports    : clk, rst (async, active-high)
//            start_i     - single-cycle run request (ignored while running)
//            dut_out_i   - DUT response
//            dut_in_o    - registered vector to DUT
//            busy_o      - run in progress
//            done_o      - run complete, result valid
//            signature_o - MISR contents
//            pass_o      - signature == GOLDEN, valid while done_o = 1
// Config   : BIST_LFSR_EN - vectors come from a maximal-length LFSR seeded
//            to 1 (2**N_IN-1 vectors, all-zero skipped). Undefined: binary
//            up-count 0 .. 2**N_IN-1.
// Revision : 1.0 - initial release
// ============================================================================
module bist_vector_engine
   import bist_pkg::*;
#(
   parameter int               N_IN     = 3,
   parameter int               N_OUT    = 3,
   parameter int               HOLD_CYC = 10,
   parameter int               SIG_W    = 8,
   parameter logic [SIG_W-1:0] POLY     = SIG_W'(DEF_POLY),
   parameter logic [SIG_W-1:0] GOLDEN   = SIG_W'(8'h0F)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [N_OUT-1:0] dut_out_i,
   output logic [N_IN-1:0]  dut_in_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [SIG_W-1:0] signature_o,
   output logic             pass_o
);

`ifdef BIST_LFSR_EN
   localparam int              NUM_VEC = (2 ** N_IN) - 1;
   localparam logic [N_IN-1:0] SEED    = N_IN'(1);
   localparam logic [7:0]      TAPS8   = lfsr_taps(N_IN);
   localparam logic [N_IN-1:0] TAPS    = TAPS8[N_IN-1:0];
`else
   localparam int              NUM_VEC = 2 ** N_IN;
   localparam logic [N_IN-1:0] SEED    = '0;
`endif

   // Hold counter needs at least one bit even when HOLD_CYC == 1.
   localparam int              HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(NUM_VEC - 1);

   state_t           state_q;
   logic [N_IN-1:0]  vec_cnt_q;
   logic [HW-1:0]    hold_cnt_q;
   logic [N_IN-1:0]  dut_in_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [SIG_W-1:0] sig_q;

   logic             capture_d;
   logic             launch_d;
   logic             misr_en_d;
   logic [SIG_W-1:0] sig_d;
   logic [SIG_W-1:0] misr_din_d;
   logic [N_IN-1:0]  vec_next_d;

   assign capture_d  = (state_q == APPLY) && (hold_cnt_q == HOLD_LAST);
   assign launch_d   = start_i && (state_q != APPLY);
   assign sig_d      = SIG_W'(misr_step(32'(sig_q), 32'(dut_out_i), 32'(POLY), SIG_W));
   // A launch clears the signature; a capture compacts the response.
   assign misr_en_d  = capture_d || launch_d;
   assign misr_din_d = launch_d ? '0 : sig_d;

`ifdef BIST_LFSR_EN
   assign vec_next_d = {dut_in_q[N_IN-2:0], ^(dut_in_q & TAPS)};
`else
   assign vec_next_d = dut_in_q + N_IN'(1);
`endif

   bist_misr #(
      .SIG_W (SIG_W)
   ) u_misr (
      .clk   (clk),
      .rst   (rst),
      .en_i  (misr_en_d),
      .din_i (misr_din_d),
      .q_o   (sig_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_cnt_q  <= '0;
         hold_cnt_q <= '0;
         dut_in_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start_i) begin
                  state_q    <= APPLY;
                  vec_cnt_q  <= '0;
                  hold_cnt_q <= '0;
                  dut_in_q   <= SEED;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
               end
            end
            APPLY: begin
               if (capture_d) begin
                  hold_cnt_q <= '0;
                  if (vec_cnt_q == VEC_LAST) begin
                     // Last capture: sig_d is the final signature.
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (sig_d == GOLDEN);
                  end else begin
                     vec_cnt_q <= vec_cnt_q + N_IN'(1);
                     dut_in_q  <= vec_next_d;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dut_in_o    = dut_in_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign signature_o = sig_q;
   assign pass_o      = pass_q;

endmodule
`default_nettype wire
